// File: rtl/mux_8_1_72_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_8_1_72_rr_arb
//  Description : Round-robin arbiter and sequencer for an 8:1 x 3-bit select
//                datapath. One requester is granted at a time. It streams
//                registered beats over a valid/ready output for up to
//                MAX_HOLD beats, then the datapath passes to the next
//                requester in round-robin order.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_HOLD   beats per grant before forced release (legal 1..15)
//  Ports
//    clk        clock, rising edge
//    rst        asynchronous active-high reset
//    req[7:0]   per-source request
//    d0..d7     3-bit source data
//    out_ready  downstream accepts the beat this cycle
//    out_valid  y holds a valid beat
//    y[2:0]     registered selected data
//    s[2:0]     select of the current or last grantee
//    gnt[7:0]   one-hot grant, zero when idle
//    busy       high while a grant is active
// ============================================================================
module mux_8_1_72_rr_arb #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [2:0] d0,
    input  logic [2:0] d1,
    input  logic [2:0] d2,
    input  logic [2:0] d3,
    input  logic [2:0] d4,
    input  logic [2:0] d5,
    input  logic [2:0] d6,
    input  logic [2:0] d7,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] y,
    output logic [2:0] s,
    output logic [7:0] gnt,
    output logic       busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] c_HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     r_state, w_state_n;
    logic [2:0] r_s,     w_s_n;
    logic [7:0] r_gnt,   w_gnt_n;
    logic [2:0] r_y,     w_y_n;
    logic [3:0] r_hold,  w_hold_n;
    logic [2:0] r_ptr,   w_ptr_n;

    logic [2:0] w_d [8];
    logic [2:0] w_ptr_rel;
    logic [3:0] w_arb_idle;   // {found, winner} searched from r_ptr
    logic [3:0] w_arb_rel;    // {found, winner} searched from the post-release pointer
    logic       w_release;

    assign w_d[0] = d0;
    assign w_d[1] = d1;
    assign w_d[2] = d2;
    assign w_d[3] = d3;
    assign w_d[4] = d4;
    assign w_d[5] = d5;
    assign w_d[6] = d6;
    assign w_d[7] = d7;

    // First requesting index at or after p, wrapping modulo 8.
    function automatic logic [3:0] f_arb(input logic [7:0] r, input logic [2:0] p);
        logic       found;
        logic [2:0] win;
        logic [2:0] idx;
        found = 1'b0;
        win   = p;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // The releasing source becomes lowest priority, so the rotated
    // search starts immediately after it.
    assign w_ptr_rel  = r_s + 3'd1;
    assign w_arb_idle = f_arb(req, r_ptr);
    assign w_arb_rel  = f_arb(req, w_ptr_rel);
    assign w_release  = !req[r_s] || (r_hold == c_HOLD_LAST);

    always_comb begin
        w_state_n = r_state;
        w_s_n     = r_s;
        w_gnt_n   = r_gnt;
        w_y_n     = r_y;
        w_hold_n  = r_hold;
        w_ptr_n   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_arb_idle[3]) begin
                    w_state_n = GRANT;
                    w_s_n     = w_arb_idle[2:0];
                    w_gnt_n   = 8'b1 << w_arb_idle[2:0];
                    w_y_n     = w_d[w_arb_idle[2:0]];
                    w_hold_n  = 4'd0;
                end
            end
            GRANT: begin
                // Without a transfer everything stays frozen.
                if (out_ready) begin
                    if (w_release) begin
                        w_ptr_n = w_ptr_rel;
                        if (w_arb_rel[3]) begin
                            // Hand over in the same edge: no bubble.
                            w_s_n    = w_arb_rel[2:0];
                            w_gnt_n  = 8'b1 << w_arb_rel[2:0];
                            w_y_n    = w_d[w_arb_rel[2:0]];
                            w_hold_n = 4'd0;
                        end else begin
                            // s and y keep the last grantee's values.
                            w_state_n = IDLE;
                            w_gnt_n   = 8'd0;
                        end
                    end else begin
                        w_hold_n = r_hold + 4'd1;
                        w_y_n    = w_d[r_s];
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= 3'd0;
            r_gnt   <= 8'd0;
            r_y     <= 3'd0;
            r_hold  <= 4'd0;
            r_ptr   <= 3'd0;
        end else begin
            r_state <= w_state_n;
            r_s     <= w_s_n;
            r_gnt   <= w_gnt_n;
            r_y     <= w_y_n;
            r_hold  <= w_hold_n;
            r_ptr   <= w_ptr_n;
        end
    end

    assign busy      = (r_state == GRANT);
    assign out_valid = busy;
    assign y         = r_y;
    assign s         = r_s;
    assign gnt       = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_8_1_72_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_8_1_72_rr_arb
//  Description : Self-checking bench for mux_8_1_72_rr_arb. Tests push the
//                beats they expect into a scoreboard queue; a negedge monitor
//                pops and compares each beat the DUT transfers. Tasks also
//                check idle/reset/stall state inline. A second instance with
//                MAX_HOLD = 1 covers forced alternation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_8_1_72_rr_arb;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] s;
        logic [2:0] y;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] d [8];
    logic       out_ready;
    logic       out_valid, busy;
    logic [2:0] y, s;
    logic [7:0] gnt;
    logic       out_valid1, busy1;
    logic [2:0] y1, s1;
    logic [7:0] gnt1;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    bit   mon_en;

    mux_8_1_72_rr_arb #(.MAX_HOLD(4)) u_dut (
        .clk(clk), .rst(rst), .req(req),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .out_ready(out_ready), .out_valid(out_valid),
        .y(y), .s(s), .gnt(gnt), .busy(busy)
    );

    mux_8_1_72_rr_arb #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .out_ready(out_ready), .out_valid(out_valid1),
        .y(y1), .s(s1), .gnt(gnt1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] src, input logic [2:0] dat);
        exp_t e;
        e.gnt = 8'b1 << src;
        e.s   = src;
        e.y   = dat;
        return e;
    endfunction

    // Scoreboard monitor: a beat is transferred at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_beat: got gnt=%h s=%0d y=%0d, expected no beat", gnt, s, y);
            end else begin
                e = sb.pop_front();
                if ({gnt, s, y} !== e) begin
                    n_err++;
                    $display("FAIL sb_beat: got gnt=%h s=%0d y=%0d, expected gnt=%h s=%0d y=%0d",
                             gnt, s, y, e.gnt, e.s, e.y);
                end
            end
        end
    end

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 3'(i);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, busy, y, s, gnt} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b busy=%b y=%0d s=%0d gnt=%h, expected all 0",
                     out_valid, busy, y, s, gnt);
        end
        n_vec++;
        if ({out_valid1, busy1, y1, s1, gnt1} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs_mh1: got valid=%b y=%0d s=%0d gnt=%h, expected all 0",
                     out_valid1, y1, s1, gnt1);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: got valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_single_beat();
        out_ready = 1'b1;
        req = 8'h20;
        sb.push_back(mk(3'd5, 3'd5));
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, s, gnt, y} !== {1'b1, 3'd5, 8'h20, 3'd5}) begin
            n_err++;
            $display("FAIL single_grant: got valid=%b s=%0d gnt=%h y=%0d, expected valid=1 s=5 gnt=20 y=5",
                     out_valid, s, gnt, y);
        end
        req = 8'h00;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, busy, gnt, s, y} !== {1'b0, 1'b0, 8'h00, 3'd5, 3'd5}) begin
            n_err++;
            $display("FAIL single_release: got valid=%b busy=%b gnt=%h s=%0d y=%0d, expected valid=0 busy=0 gnt=00 s=5 y=5",
                     out_valid, busy, gnt, s, y);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL single_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    // Pointer is 6 after the single beat: source 6 first, then source 0.
    task automatic test_fairness();
        req = 8'b0100_0001;
        for (int b = 0; b < 4; b++) sb.push_back(mk(3'd6, 3'd6));
        for (int b = 0; b < 4; b++) sb.push_back(mk(3'd0, 3'd0));
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1 req = 8'h00;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, gnt} !== 9'd0) begin
            n_err++;
            $display("FAIL fair_idle: got valid=%b gnt=%h, expected valid=0 gnt=00", out_valid, gnt);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL fair_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    // Pointer is 1: source 3 wins over 4, stalls after its first beat,
    // then must still get exactly four beats before source 4 takes over.
    task automatic test_stall();
        req = 8'h18;
        sb.push_back(mk(3'd3, 3'd3));
        sb.push_back(mk(3'd3, 3'd5));
        sb.push_back(mk(3'd3, 3'd7));
        sb.push_back(mk(3'd3, 3'd1));
        sb.push_back(mk(3'd4, 3'd4));
        @(posedge clk);
        #1 d[3] = 3'd5;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        req = 8'hA5;
        d[3] = 3'd6;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({out_valid, y, s, gnt} !== {1'b1, 3'd5, 3'd3, 8'h08}) begin
                n_err++;
                $display("FAIL stall_frozen: got valid=%b y=%0d s=%0d gnt=%h, expected valid=1 y=5 s=3 gnt=08",
                         out_valid, y, s, gnt);
            end
            req  = 8'($urandom);
            d[3] = 3'($urandom);
        end
        out_ready = 1'b1;
        req = 8'h18;
        d[3] = 3'd7;
        @(posedge clk);
        #1 d[3] = 3'd1;
        @(posedge clk);
        @(posedge clk);
        #1 req = 8'h00;
        @(posedge clk);
        #1;
        d[3] = 3'd3;
        n_vec++;
        if ({out_valid, gnt, s} !== {1'b0, 8'h00, 3'd4}) begin
            n_err++;
            $display("FAIL stall_end_idle: got valid=%b gnt=%h s=%0d, expected valid=0 gnt=00 s=4",
                     out_valid, gnt, s);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL stall_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        req = 8'h40;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, gnt} !== {1'b1, 8'h40}) begin
            n_err++;
            $display("FAIL arst_pre_grant: got valid=%b gnt=%h, expected valid=1 gnt=40", out_valid, gnt);
        end
        #2 rst = 1'b1;
        req = 8'h00;
        #1;
        n_vec++;
        if ({out_valid, busy, gnt, s, y} !== 15'd0) begin
            n_err++;
            $display("FAIL arst_immediate: got valid=%b busy=%b gnt=%h s=%0d y=%0d, expected all 0",
                     out_valid, busy, gnt, s, y);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        // With ptr back at 0, source 1 beats source 6.
        req = 8'h42;
        sb.push_back(mk(3'd1, 3'd1));
        @(posedge clk);
        #1 req = 8'h00;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, gnt} !== 9'd0) begin
            n_err++;
            $display("FAIL arst_after_idle: got valid=%b gnt=%h, expected valid=0 gnt=00", out_valid, gnt);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL arst_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        req = 8'hFF;
        for (int r = 0; r < 9; r++)
            for (int b = 0; b < 4; b++)
                sb.push_back(mk(3'(r % 8), 3'(r % 8)));
        @(posedge clk);
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_no_bubble: got valid=%b at cycle %0d, expected 1", out_valid, c);
            end
        end
        req = 8'h00;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, gnt, s} !== {1'b0, 8'h00, 3'd0}) begin
            n_err++;
            $display("FAIL b2b_idle: got valid=%b gnt=%h s=%0d, expected valid=0 gnt=00 s=0",
                     out_valid, gnt, s);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_alternation();
        logic [2:0] exp_s;
        mon_en = 1'b0;
        pulse_reset();
        req = 8'h18;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_s = (i % 2 == 0) ? 3'd3 : 3'd4;
            n_vec++;
            if ({out_valid1, s1, gnt1, y1} !== {1'b1, exp_s, 8'b1 << exp_s, exp_s}) begin
                n_err++;
                $display("FAIL alt_beat%0d: got valid=%b s=%0d gnt=%h y=%0d, expected valid=1 s=%0d y=%0d",
                         i, out_valid1, s1, gnt1, y1, exp_s, exp_s);
            end
            @(posedge clk);
        end
        #1 req = 8'h00;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL alt_idle: got valid=%b, expected 0", out_valid1);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        mon_en = 1'b1;
        test_reset();
        test_single_beat();
        test_fairness();
        test_stall();
        test_async_reset();
        test_back_to_back();
        test_alternation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
